// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// load_store_unit : single-outstanding load/store unit with bus timeout/flush
// Revision 1.0
// ============================================================================
module load_store_unit #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [6:0]        i_opcode,
    input  logic [2:0]        i_funct3,
    input  logic [31:0]       i_alu_result,
    input  logic [31:0]       i_rs2,
    input  logic [4:0]        i_rd_addr,
    input  logic              i_rd_write,
    input  logic [31:0]       i_pc,
    input  logic              i_flush,
    output logic              o_stb,
    output logic              o_we,
    output logic [ADDR_W-1:0] o_addr,
    output logic [31:0]       o_wdata,
    output logic [3:0]        o_sel,
    input  logic              i_ack,
    input  logic              i_err,
    input  logic [31:0]       i_rdata,
    output logic              o_valid,
    output logic [4:0]        o_rd_addr,
    output logic              o_rd_write,
    output logic [31:0]       o_rd_data,
    output logic [31:0]       o_pc,
    output logic              o_exc,
    output logic [3:0]        o_exc_cause,
    output logic              o_stall
);
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam int         CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic             pend_store, pend_rd_write;
    logic [2:0]       pend_f3;
    logic [1:0]       pend_off;

    logic        is_load, is_store, is_mem, illegal, misaligned, accept, timeout_hit;
    logic        bus_done, commit;
    logic [1:0]  off;
    logic [31:0] st_wdata, ld_shift, ld_data;
    logic [3:0]  st_sel;

    assign off      = i_alu_result[1:0];
    assign is_load  = (i_opcode == OP_LOAD);
    assign is_store = (i_opcode == OP_STORE);
    assign is_mem   = is_load | is_store;
    assign o_ready  = (state == S_IDLE) && !i_rst;
    assign o_stall  = !o_ready;
    assign accept   = i_valid && o_ready && !i_flush;

    assign illegal = is_load  ? (i_funct3 == 3'd3 || i_funct3 == 3'd6 || i_funct3 == 3'd7)
                   : is_store ? (i_funct3 >= 3'd3) : 1'b0;
    assign misaligned = is_mem && ((i_funct3[1:0] == 2'b01 && off[0]) ||
                                   (i_funct3[1:0] == 2'b10 && off != 2'b00));

    assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == CNT_W'(TIMEOUT - 1));
    // ack takes priority over an expiring timeout in the same cycle
    assign bus_done    = i_ack || timeout_hit;
    assign commit      = (state == S_WAIT) && bus_done && !i_flush;

    always_comb begin
        st_wdata = i_rs2;
        st_sel   = 4'b1111;
        if (is_store) begin
            case (i_funct3[1:0])
                2'b00: begin
                    st_wdata = {4{i_rs2[7:0]}};
                    st_sel   = 4'b0001 << off;
                end
                2'b01: begin
                    st_wdata = {2{i_rs2[15:0]}};
                    st_sel   = off[1] ? 4'b1100 : 4'b0011;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        ld_shift = i_rdata >> {pend_off, 3'b000};
        case (pend_f3)
            3'd0:    ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
            3'd1:    ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
            3'd4:    ld_data = {24'd0, ld_shift[7:0]};
            3'd5:    ld_data = {16'd0, ld_shift[15:0]};
            default: ld_data = ld_shift;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept && is_mem && !illegal && !misaligned) state_nxt = S_WAIT;
            S_WAIT:  if (bus_done) state_nxt = S_IDLE;
                     else if (i_flush) state_nxt = S_DRAIN;
            S_DRAIN: if (bus_done) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wait_cnt      <= '0;
            pend_store    <= 1'b0;
            pend_rd_write <= 1'b0;
            pend_f3       <= 3'd0;
            pend_off      <= 2'd0;
            o_stb         <= 1'b0;
            o_we          <= 1'b0;
            o_addr        <= '0;
            o_wdata       <= 32'd0;
            o_sel         <= 4'd0;
            o_valid       <= 1'b0;
            o_rd_addr     <= 5'd0;
            o_rd_write    <= 1'b0;
            o_rd_data     <= 32'd0;
            o_pc          <= 32'd0;
            o_exc         <= 1'b0;
            o_exc_cause   <= 4'd0;
        end else begin
            o_valid     <= 1'b0;
            o_exc       <= 1'b0;
            o_exc_cause <= 4'd0;
            if (state == S_IDLE) begin
                if (accept) begin
                    o_rd_addr <= i_rd_addr;
                    o_pc      <= i_pc;
                    if (!is_mem) begin
                        o_valid    <= 1'b1;
                        o_rd_write <= i_rd_write;
                        o_rd_data  <= i_alu_result;
                    end else if (illegal || misaligned) begin
                        o_valid     <= 1'b1;
                        o_exc       <= 1'b1;
                        o_rd_write  <= 1'b0;
                        o_exc_cause <= illegal ? 4'd2 : (is_store ? 4'd6 : 4'd4);
                    end else begin
                        o_stb         <= 1'b1;
                        o_we          <= is_store;
                        o_addr        <= {i_alu_result[ADDR_W-1:2], 2'b00};
                        o_wdata       <= st_wdata;
                        o_sel         <= st_sel;
                        pend_store    <= is_store;
                        pend_rd_write <= i_rd_write;
                        pend_f3       <= i_funct3;
                        pend_off      <= off;
                        wait_cnt      <= '0;
                    end
                end
            end else if (bus_done) begin
                o_stb <= 1'b0;
                if (commit) begin
                    o_valid <= 1'b1;
                    if (i_ack && !i_err) begin
                        o_rd_write <= pend_store ? 1'b0 : pend_rd_write;
                        if (!pend_store) o_rd_data <= ld_data;
                    end else begin
                        o_rd_write  <= 1'b0;
                        o_exc       <= 1'b1;
                        o_exc_cause <= pend_store ? 4'd7 : 4'd5;
                    end
                end
            end else begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end
endmodule
`default_nettype wire
